demux_nway: RTL and testbench

Single-clock, parametrised narrow-to-wide demultiplexer for the fabric output port. It pops RATIO words of WIDTH_IN from a show-ahead FIFO interface and packs them, first-received in lane 0, into one WIDTH_OUT word. That word is presented on a valid/ready interface toward the RTL side. A registered output stage lets the next word fill while the previous one waits, and optional packet-boundary flushing emits partially filled words.

---
 rtl/demux_nway_pkg.sv | 7 +
 rtl/demux_nway_outreg.sv | 34 +++
 rtl/demux_nway.sv | 57 +++++
 tb/tb_demux_nway.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/demux_nway_pkg.sv
// demux_nway_pkg: shared width helper and output-register state type for the width converters.
package demux_nway_pkg;
   typedef enum logic {OUT_EMPTY = 1'b0, OUT_FULL = 1'b1} out_state_t;
   function automatic int min_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/demux_nway_outreg.sv
// demux_nway_outreg: one-entry output holding register with valid/ready hold logic.
module demux_nway_outreg
   import demux_nway_pkg::*;
#(
   parameter int W  = 16,
   parameter int CW = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic [W-1:0]  load_data,
   input  logic [CW-1:0] load_count,
   input  logic          ready,
   output logic          valid,
   output logic [W-1:0]  data,
   output logic [CW-1:0] count,
   output logic          can_load
);
   out_state_t state;
   assign valid    = state == OUT_FULL;
   // A load may land on the same edge the held word is accepted.
   assign can_load = state == OUT_EMPTY || ready;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= OUT_EMPTY;
         data  <= '0;
         count <= '0;
      end else if (load) begin
         state <= OUT_FULL;
         data  <= load_data;
         count <= load_count;
      end else if (ready)
         state <= OUT_EMPTY;
endmodule

// File: rtl/demux_nway.sv
// demux_nway: packs RATIO narrow words from a show-ahead FIFO into one wide valid/ready word.
// Define DEMUX_NWAY_FLUSH_EN to let i_last_in close a partially filled word early.
module demux_nway
   import demux_nway_pkg::*;
#(
   parameter int WIDTH_IN  = 4,
   parameter int RATIO     = 4,
   parameter int WIDTH_OUT = WIDTH_IN * RATIO,
   parameter int CNT_W     = $clog2(RATIO + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WIDTH_IN-1:0]  i_data_in,
   input  logic                 i_empty_in,
   input  logic                 i_last_in,
   output logic                 i_read_en,
   output logic [WIDTH_OUT-1:0] o_data_out,
   output logic                 o_valid_out,
   input  logic                 o_ready_in,
   output logic [CNT_W-1:0]     o_count_out
);
   localparam int LW = min_w(RATIO);
   localparam logic [LW-1:0] LAST = LW'(RATIO - 1);
   logic [LW-1:0]        lane_idx;
   logic [WIDTH_OUT-1:0] acc, merged;
   logic                 completes, can_load;
`ifdef DEMUX_NWAY_FLUSH_EN
   assign completes = lane_idx == LAST || i_last_in;
`else
   assign completes = lane_idx == LAST;
`endif
   assign i_read_en = ~rst & ~i_empty_in & (~completes | can_load);
   always_comb begin
      merged = acc;
      merged[lane_idx * WIDTH_IN +: WIDTH_IN] = i_data_in;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         lane_idx <= '0;
         acc      <= '0;
      end else if (i_read_en) begin
         lane_idx <= completes ? '0 : lane_idx + LW'(1);
         acc      <= completes ? '0 : merged;
      end
   demux_nway_outreg #(.W(WIDTH_OUT), .CW(CNT_W)) u_outreg (
      .clk        (clk),
      .rst        (rst),
      .load       (i_read_en & completes),
      .load_data  (merged),
      .load_count (CNT_W'(lane_idx) + CNT_W'(1)),
      .ready      (o_ready_in),
      .valid      (o_valid_out),
      .data       (o_data_out),
      .count      (o_count_out),
      .can_load   (can_load)
   );
endmodule

// File: tb/tb_demux_nway.sv
// tb_demux_nway: directed and random stimulus against a queue-based packing model.
module tb_demux_nway;
   localparam int W = 4, R = 4, WO = 16, CW = 3;
`ifdef DEMUX_NWAY_FLUSH_EN
   localparam bit FLUSH = 1'b1;
`else
   localparam bit FLUSH = 1'b0;
`endif
   logic clk = 1'b0, rst = 1'b1;
   logic [W-1:0]  i_data_in = '0;
   logic          i_empty_in = 1'b1, i_last_in = 1'b0, i_read_en;
   logic [WO-1:0] o_data_out;
   logic          o_valid_out, o_ready_in = 1'b1;
   logic [CW-1:0] o_count_out;
   always #5 clk = ~clk;
   demux_nway #(.WIDTH_IN(W), .RATIO(R)) dut (
      .clk(clk), .rst(rst), .i_data_in(i_data_in), .i_empty_in(i_empty_in),
      .i_last_in(i_last_in), .i_read_en(i_read_en), .o_data_out(o_data_out),
      .o_valid_out(o_valid_out), .o_ready_in(o_ready_in), .o_count_out(o_count_out)
   );
   int checks = 0, errors = 0;
   logic [W:0]    src[$];
   logic [WO-1:0] exp_d[$];
   logic [CW-1:0] exp_c[$];
   logic [WO-1:0] acc_m = '0, last_data = '0, hold_d = '0;
   logic [CW-1:0] last_cnt = '0, hold_c = '0;
   logic          hold_prev = 1'b0;
   int n_m = 0, gap_pct = 0, stall_pct = 0, words = 0, vcycles = 0, w0 = 0;
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask
   task automatic push(input logic last, input logic [W-1:0] d);
      src.push_back({last, d});
   endtask
   // One clock: drive at negedge, check mid-cycle, update the model after the edge.
   task automatic cycle();
      logic [W:0] head;
      logic compl, popped;
      @(negedge clk);
      i_empty_in = src.size() == 0 || $urandom_range(99) < gap_pct;
      head = src.size() != 0 ? src[0] : (W+1)'($urandom);
      i_data_in = head[W-1:0];
      i_last_in = head[W];
      o_ready_in = $urandom_range(99) >= stall_pct;
      #1;
      compl = n_m == R - 1 || (FLUSH && i_last_in);
      check("read_en", i_read_en, !i_empty_in && (!compl || !o_valid_out || o_ready_in));
      check("valid", o_valid_out, exp_d.size() != 0);
      if (hold_prev) begin
         check("hold_data", o_data_out, hold_d);
         check("hold_cnt", o_count_out, hold_c);
      end
      if (o_valid_out) vcycles++;
      if (o_valid_out && o_ready_in && exp_d.size() != 0) begin
         check("data", o_data_out, exp_d[0]);
         check("count", o_count_out, exp_c[0]);
         last_data = o_data_out;
         last_cnt = o_count_out;
         words++;
         void'(exp_d.pop_front());
         void'(exp_c.pop_front());
      end
      hold_prev = o_valid_out && !o_ready_in;
      hold_d = o_data_out;
      hold_c = o_count_out;
      popped = i_read_en;
      @(posedge clk);
      if (popped && src.size() != 0) begin
         acc_m[n_m*W +: W] = head[W-1:0];
         n_m++;
         if (compl) begin
            exp_d.push_back(acc_m);
            exp_c.push_back(CW'(n_m));
            acc_m = '0;
            n_m = 0;
         end
         void'(src.pop_front());
      end
   endtask
   task automatic drain(input int limit);
      int b = 0;
      while ((src.size() != 0 || exp_d.size() != 0) && b < limit) begin
         cycle();
         b++;
      end
      check("drain_bound", b < limit, 1'b1);
   endtask
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      i_empty_in = 1'b0;
      #1;
      check("rst_read_en", i_read_en, 1'b0);
      check("rst_valid", o_valid_out, 1'b0);
      check("rst_data", o_data_out, '0);
      check("rst_count", o_count_out, '0);
      @(negedge clk);
      rst = 1'b0;
      i_empty_in = 1'b1;
      src.delete();
      exp_d.delete();
      exp_c.delete();
      acc_m = '0;
      n_m = 0;
      hold_prev = 1'b0;
   endtask
   initial begin
      do_reset();
      // basic pack
      w0 = words;
      vcycles = 0;
      push(0, 4'hD); push(0, 4'h9); push(0, 4'h9); push(0, 4'hB);
      drain(50);
      repeat (3) cycle();
      check("basic_data", last_data, 16'hB99D);
      check("basic_cnt", last_cnt, 3'd4);
      check("basic_vcycles", vcycles, 1);
      check("basic_words", words - w0, 1);
      // continuous stream 0..31
      w0 = words;
      for (int i = 0; i < 32; i++) push(0, W'(i));
      drain(100);
      check("stream_words", words - w0, 8);
      check("stream_last", last_data, 16'hFEDC);
      // backpressure for 10 cycles after the first word
      w0 = words;
      for (int i = 0; i < 8; i++) push(0, W'(i + 5));
      for (int b = 0; b < 20 && exp_d.size() == 0; b++) cycle();
      check("bp_first", exp_d.size(), 1);
      stall_pct = 100;
      repeat (10) cycle();
      stall_pct = 0;
      drain(50);
      check("bp_words", words - w0, 2);
      check("bp_last", last_data, 16'hCBA9);
      // packet-boundary flush
      w0 = words;
      push(0, 4'hC); push(1, 4'h8);
      drain(50);
      repeat (2) cycle();
`ifdef DEMUX_NWAY_FLUSH_EN
      check("flush_data", last_data, 16'h008C);
      check("flush_cnt", last_cnt, 3'd2);
`else
      check("noflush_wait", words - w0, 0);
      push(0, 4'h1); push(0, 4'h2);
      drain(50);
      check("noflush_data", last_data, 16'h218C);
      check("noflush_cnt", last_cnt, 3'd4);
`endif
      // reset mid-word
      push(0, 4'h7); push(0, 4'h6);
      drain(50);
      do_reset();
      push(0, 4'h1); push(0, 4'h2); push(0, 4'h3); push(0, 4'h4);
      drain(50);
      repeat (2) cycle();
      check("rst_mid_data", last_data, 16'h4321);
      check("rst_mid_cnt", last_cnt, 3'd4);
      // random traffic with gaps, stalls and packet ends
      gap_pct = 30;
      stall_pct = 30;
      for (int i = 0; i < 300; i++) push($urandom_range(9) == 0, W'($urandom));
      drain(3000);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
